// File: rtl/riscv_v_bypass_pipe_if.sv
// rtl/riscv_v_bypass_pipe_if.sv - EXE write, late data, operand read and RF write signals of riscv_v_bypass_pipe
interface riscv_v_bypass_pipe_if #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_SRCS   = 3,
  parameter int ADDR_WIDTH = 5
);
  localparam int NB = DATA_WIDTH / 8;

  logic                           adv_i;
  logic                           wr_valid_exe_i;
  logic [ADDR_WIDTH-1:0]          wr_addr_exe_i;
  logic [NB-1:0]                  wr_be_exe_i;
  logic [DATA_WIDTH-1:0]          wr_data_exe_i;
  logic                           wr_rdy_exe_i;
  logic                           late_valid_i;
  logic [DATA_WIDTH-1:0]          late_data_i;
  logic [NUM_SRCS-1:0]            src_valid_i;
  logic [NUM_SRCS*ADDR_WIDTH-1:0] src_addr_i;
  logic [NUM_SRCS*DATA_WIDTH-1:0] src_rf_data_i;
  logic [NUM_SRCS*DATA_WIDTH-1:0] src_byp_o;
  logic                           hazard_o;
  logic [NB-1:0]                  rf_wr_en_o;
  logic [ADDR_WIDTH-1:0]          rf_wr_addr_o;
  logic [DATA_WIDTH-1:0]          rf_wr_data_o;
  logic                           err_o;

  modport master (
    output adv_i, wr_valid_exe_i, wr_addr_exe_i, wr_be_exe_i, wr_data_exe_i, wr_rdy_exe_i,
           late_valid_i, late_data_i, src_valid_i, src_addr_i, src_rf_data_i,
    input  src_byp_o, hazard_o, rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, err_o
  );

  modport slave (
    input  adv_i, wr_valid_exe_i, wr_addr_exe_i, wr_be_exe_i, wr_data_exe_i, wr_rdy_exe_i,
           late_valid_i, late_data_i, src_valid_i, src_addr_i, src_rf_data_i,
    output src_byp_o, hazard_o, rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, err_o
  );
endinterface

// File: rtl/riscv_v_bypass_pipe.sv
// rtl/riscv_v_bypass_pipe.sv - vector writeback pipe with youngest-first per-byte forwarding
// RISCV_V_BYPASS_PERF_EN adds saturating forward/hazard cycle counters.
module riscv_v_bypass_pipe #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_SRCS   = 3,
  parameter int NUM_STAGES = 3,
  parameter int LATE_STAGE = 2,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  riscv_v_bypass_pipe_if.slave  bus
`ifdef RISCV_V_BYPASS_PERF_EN
  ,
  output logic [31:0]           perf_fwd_cnt_o,
  output logic [31:0]           perf_haz_cnt_o
`endif
);
  localparam int NB = DATA_WIDTH / 8;

  logic [NUM_STAGES:1]   vld_q, vld_d, rdy_q, rdy_d, eff_rdy;
  logic [ADDR_WIDTH-1:0] addr_q [1:NUM_STAGES];
  logic [ADDR_WIDTH-1:0] addr_d [1:NUM_STAGES];
  logic [NB-1:0]         be_q   [1:NUM_STAGES];
  logic [NB-1:0]         be_d   [1:NUM_STAGES];
  logic [DATA_WIDTH-1:0] data_q [1:NUM_STAGES];
  logic [DATA_WIDTH-1:0] data_d [1:NUM_STAGES];
  logic [DATA_WIDTH-1:0] eff_data [1:NUM_STAGES];
  logic                  late_fill, err_q, err_d, hazard, any_fwd;
  logic [NUM_SRCS*DATA_WIDTH-1:0] byp;

  assign late_fill = vld_q[LATE_STAGE] & ~rdy_q[LATE_STAGE] & bus.late_valid_i;

  // Effective view: the late-stage record looks ready as soon as its data shows up.
  always_comb begin
    for (int k = 1; k <= NUM_STAGES; k++) begin
      eff_rdy[k]  = rdy_q[k];
      eff_data[k] = data_q[k];
    end
    if (late_fill) begin
      eff_rdy[LATE_STAGE]  = 1'b1;
      eff_data[LATE_STAGE] = bus.late_data_i;
    end
  end

  always_comb begin
    for (int k = 1; k <= NUM_STAGES; k++) begin
      vld_d[k]  = vld_q[k];
      addr_d[k] = addr_q[k];
      be_d[k]   = be_q[k];
      data_d[k] = eff_data[k];
      rdy_d[k]  = eff_rdy[k];
    end
    if (bus.adv_i) begin
      vld_d[1]  = bus.wr_valid_exe_i;
      addr_d[1] = bus.wr_addr_exe_i;
      be_d[1]   = bus.wr_be_exe_i;
      data_d[1] = bus.wr_data_exe_i;
      rdy_d[1]  = bus.wr_rdy_exe_i;
      for (int k = 2; k <= NUM_STAGES; k++) begin
        vld_d[k]  = vld_q[k-1];
        addr_d[k] = addr_q[k-1];
        be_d[k]   = be_q[k-1];
        data_d[k] = eff_data[k-1];
        rdy_d[k]  = eff_rdy[k-1];
      end
    end
    err_d = err_q
          | (bus.adv_i & vld_q[LATE_STAGE] & ~eff_rdy[LATE_STAGE])
          | (bus.late_valid_i & ~(vld_q[LATE_STAGE] & ~rdy_q[LATE_STAGE]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      rdy_q <= '0;
      err_q <= 1'b0;
      for (int k = 1; k <= NUM_STAGES; k++) begin
        addr_q[k] <= '0;
        be_q[k]   <= '0;
        data_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      rdy_q <= rdy_d;
      err_q <= err_d;
      for (int k = 1; k <= NUM_STAGES; k++) begin
        addr_q[k] <= addr_d[k];
        be_q[k]   <= be_d[k];
        data_q[k] <= data_d[k];
      end
    end
  end

  // Oldest-to-youngest scan so the youngest matching stage overwrites each byte last.
  always_comb begin
    logic       hit;
    logic       sel_rdy;
    logic [7:0] sel_byte;
    byp      = '0;
    hazard   = 1'b0;
    any_fwd  = 1'b0;
    hit      = 1'b0;
    sel_rdy  = 1'b1;
    sel_byte = '0;
    for (int s = 0; s < NUM_SRCS; s++) begin
      for (int b = 0; b < NB; b++) begin
        hit      = 1'b0;
        sel_rdy  = 1'b1;
        sel_byte = bus.src_rf_data_i[(s*NB+b)*8 +: 8];
        for (int k = NUM_STAGES; k >= 1; k--) begin
          if (vld_q[k] && addr_q[k] == bus.src_addr_i[s*ADDR_WIDTH +: ADDR_WIDTH] && be_q[k][b]) begin
            hit      = 1'b1;
            sel_rdy  = eff_rdy[k];
            sel_byte = eff_data[k][b*8 +: 8];
          end
        end
        byp[(s*NB+b)*8 +: 8] = sel_byte;
        if (bus.src_valid_i[s] && hit) begin
          any_fwd = 1'b1;
          if (!sel_rdy) hazard = 1'b1;
        end
      end
    end
  end

  assign bus.src_byp_o    = byp;
  assign bus.hazard_o     = hazard;
  assign bus.err_o        = err_q;
  assign bus.rf_wr_en_o   = be_q[NUM_STAGES] & {NB{vld_q[NUM_STAGES] & bus.adv_i}};
  assign bus.rf_wr_addr_o = addr_q[NUM_STAGES];
  assign bus.rf_wr_data_o = data_q[NUM_STAGES];

`ifdef RISCV_V_BYPASS_PERF_EN
  logic [31:0] fwd_cnt_q, haz_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q <= '0;
      haz_cnt_q <= '0;
    end else begin
      if (any_fwd && fwd_cnt_q != 32'hFFFF_FFFF) fwd_cnt_q <= fwd_cnt_q + 32'd1;
      if (hazard && haz_cnt_q != 32'hFFFF_FFFF) haz_cnt_q <= haz_cnt_q + 32'd1;
    end
  end

  assign perf_fwd_cnt_o = fwd_cnt_q;
  assign perf_haz_cnt_o = haz_cnt_q;
`endif
endmodule

// File: tb/tb_riscv_v_bypass_pipe.sv
// tb/tb_riscv_v_bypass_pipe.sv - randomized bench for riscv_v_bypass_pipe against a queue-based reference model
module tb_riscv_v_bypass_pipe;
  localparam int DW  = 128;
  localparam int NS  = 3;
  localparam int NST = 3;
  localparam int LS  = 2;
  localparam int AW  = 5;
  localparam int NB  = DW / 8;

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [NB-1:0] be;
    logic [DW-1:0] d;
    logic          r;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  rec_t pipe[$];          // index 0 = youngest in-flight record
  logic m_err;
  logic exp_haz, exp_fwd;
`ifdef RISCV_V_BYPASS_PERF_EN
  logic [31:0] perf_fwd_cnt, perf_haz_cnt;
  logic [31:0] m_fwd_cnt, m_haz_cnt;
`endif

  always #5 clk = ~clk;

  riscv_v_bypass_pipe_if #(.DATA_WIDTH(DW), .NUM_SRCS(NS), .ADDR_WIDTH(AW)) bus ();

  riscv_v_bypass_pipe #(
    .DATA_WIDTH(DW), .NUM_SRCS(NS), .NUM_STAGES(NST), .LATE_STAGE(LS), .ADDR_WIDTH(AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef RISCV_V_BYPASS_PERF_EN
    ,
    .perf_fwd_cnt_o (perf_fwd_cnt),
    .perf_haz_cnt_o (perf_haz_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic rec_t eff_rec(input int k);
    rec_t r = pipe[k];
    if (k == LS-1 && r.v && !r.r && bus.late_valid_i) begin
      r.d = bus.late_data_i;
      r.r = 1'b1;
    end
    return r;
  endfunction

  task automatic model_reset();
    rec_t z;
    z.v = 0; z.a = '0; z.be = '0; z.d = '0; z.r = 0;
    pipe.delete();
    for (int k = 0; k < NST; k++) pipe.push_back(z);
    m_err = 1'b0;
`ifdef RISCV_V_BYPASS_PERF_EN
    m_fwd_cnt = '0;
    m_haz_cnt = '0;
`endif
  endtask

  task automatic clear_inputs();
    bus.adv_i = 0; bus.wr_valid_exe_i = 0; bus.wr_addr_exe_i = '0; bus.wr_be_exe_i = '0;
    bus.wr_data_exe_i = '0; bus.wr_rdy_exe_i = 0; bus.late_valid_i = 0; bus.late_data_i = '0;
    bus.src_valid_i = '0; bus.src_addr_i = '0; bus.src_rf_data_i = '0;
  endtask

  task automatic set_exe(input logic v, input logic [AW-1:0] a, input logic [NB-1:0] be,
                         input logic [DW-1:0] d, input logic r);
    bus.wr_valid_exe_i = v; bus.wr_addr_exe_i = a; bus.wr_be_exe_i = be;
    bus.wr_data_exe_i = d; bus.wr_rdy_exe_i = r;
  endtask

  task automatic set_src(input int s, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] rf);
    bus.src_valid_i[s] = v;
    bus.src_addr_i[s*AW +: AW] = a;
    bus.src_rf_data_i[s*DW +: DW] = rf;
  endtask

  // Called just after a negedge once inputs are set: compare every output with the model.
  task automatic settle();
    logic [DW-1:0] exp_byp;
    rec_t r;
    #1;
    exp_haz = 0;
    exp_fwd = 0;
    for (int s = 0; s < NS; s++) begin
      exp_byp = bus.src_rf_data_i[s*DW +: DW];
      for (int b = 0; b < NB; b++) begin
        for (int k = 0; k < NST; k++) begin
          r = eff_rec(k);
          if (r.v && r.a == bus.src_addr_i[s*AW +: AW] && r.be[b]) begin
            exp_byp[b*8 +: 8] = r.d[b*8 +: 8];
            if (bus.src_valid_i[s]) begin
              exp_fwd = 1;
              if (!r.r) exp_haz = 1;
            end
            break;
          end
        end
      end
      check_eq($sformatf("byp%0d", s), bus.src_byp_o[s*DW +: DW], exp_byp);
    end
    r = pipe[NST-1];
    check_eq("hazard", bus.hazard_o, exp_haz);
    check_eq("rf_wr_en", bus.rf_wr_en_o, (r.v && bus.adv_i) ? r.be : '0);
    check_eq("rf_wr_addr", bus.rf_wr_addr_o, r.a);
    check_eq("rf_wr_data", bus.rf_wr_data_o, r.d);
    check_eq("err", bus.err_o, m_err);
`ifdef RISCV_V_BYPASS_PERF_EN
    check_eq("perf_fwd", perf_fwd_cnt, m_fwd_cnt);
    check_eq("perf_haz", perf_haz_cnt, m_haz_cnt);
`endif
  endtask

  task automatic advance();
    rec_t e, n;
    @(posedge clk);
    e = eff_rec(LS-1);
    m_err = m_err | (bus.adv_i && e.v && !e.r)
                  | (bus.late_valid_i && !(pipe[LS-1].v && !pipe[LS-1].r));
`ifdef RISCV_V_BYPASS_PERF_EN
    if (exp_fwd && m_fwd_cnt != 32'hFFFF_FFFF) m_fwd_cnt++;
    if (exp_haz && m_haz_cnt != 32'hFFFF_FFFF) m_haz_cnt++;
`endif
    pipe[LS-1] = e;
    if (bus.adv_i) begin
      n.v = bus.wr_valid_exe_i; n.a = bus.wr_addr_exe_i; n.be = bus.wr_be_exe_i;
      n.d = bus.wr_data_exe_i;  n.r = bus.wr_rdy_exe_i;
      pipe.delete(NST-1);
      pipe.push_front(n);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [DW-1:0] rfd;
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // reset state
    settle();
    check_eq("reset_err", bus.err_o, 0);
    check_eq("reset_wr_en", bus.rf_wr_en_o, 0);

    // back-to-back forwarding and single retire
    bus.adv_i = 1;
    set_exe(1, 5'd3, '1, {16{8'h11}}, 1);
    settle(); advance();
    set_exe(0, '0, '0, '0, 0);
    set_src(0, 1, 5'd3, '0);
    settle();
    check_eq("b2b_byp", bus.src_byp_o[DW-1:0], {16{8'h11}});
    check_eq("b2b_haz", bus.hazard_o, 0);
    advance();
    settle(); check_eq("b2b_en_s2", bus.rf_wr_en_o, 0); advance();
    settle(); check_eq("b2b_en_ret", bus.rf_wr_en_o, 16'hFFFF);
    check_eq("b2b_addr", bus.rf_wr_addr_o, 3); advance();
    settle(); check_eq("b2b_en_once", bus.rf_wr_en_o, 0); advance();

    // partial byte-enable merge
    clear_inputs(); bus.adv_i = 1;
    set_exe(1, 5'd5, 16'h00FF, {16{8'hAA}}, 1); settle(); advance();
    set_exe(1, 5'd5, 16'h0F0F, {16{8'hBB}}, 1); settle(); advance();
    clear_inputs();
    set_src(1, 1, 5'd5, {16{8'hCC}});
    settle();
    check_eq("merge", bus.src_byp_o[DW +: DW], 128'hCCCCCCCC_BBBBBBBB_AAAAAAAA_BBBBBBBB);
    advance();

    // load-use with late fill while held
    do_reset(); clear_inputs(); bus.adv_i = 1;
    set_exe(1, 5'd7, '1, '0, 0); settle(); advance();
    set_exe(0, '0, '0, '0, 0); set_src(0, 1, 5'd7, '0);
    settle(); check_eq("lu_haz_s1", bus.hazard_o, 1); advance();
    bus.adv_i = 0;
    settle(); check_eq("lu_haz_s2", bus.hazard_o, 1); advance();
    bus.late_valid_i = 1; bus.late_data_i = {16{8'h55}};
    settle();
    check_eq("lu_haz_fill", bus.hazard_o, 0);
    check_eq("lu_byp_fill", bus.src_byp_o[DW-1:0], {16{8'h55}});
    advance();
    bus.late_valid_i = 0; bus.late_data_i = '0; bus.adv_i = 1;
    settle(); check_eq("lu_byp_kept", bus.src_byp_o[DW-1:0], {16{8'h55}}); advance();
    settle(); check_eq("lu_err", bus.err_o, 0); advance();

    // protocol error: unready record pushed past the late stage
    do_reset(); clear_inputs(); bus.adv_i = 1;
    set_exe(1, 5'd7, '1, '0, 0); settle(); advance();
    set_exe(0, '0, '0, '0, 0); settle(); advance();
    settle(); advance();
    settle(); check_eq("perr_set", bus.err_o, 1); advance();
    settle(); advance();
    settle(); check_eq("perr_sticky", bus.err_o, 1); advance();
    do_reset();
    settle(); check_eq("perr_clr", bus.err_o, 0);

    // asynchronous reset mid-flight
    clear_inputs(); bus.adv_i = 1;
    set_exe(1, 5'd1, '1, rand_data(), 1); settle(); advance();
    set_exe(1, 5'd2, '1, rand_data(), 1); settle(); advance();
    set_exe(1, 5'd3, '1, rand_data(), 0); settle(); advance();
    set_exe(0, '0, '0, '0, 0);
    rfd = rand_data();
    set_src(0, 1, 5'd3, rfd);
    settle();
    check_eq("ar_haz_pre", bus.hazard_o, 1);
    check_eq("ar_en_pre", bus.rf_wr_en_o, 16'hFFFF);
    #1 rst_n = 1'b0;
    #1;
    check_eq("ar_en", bus.rf_wr_en_o, 0);
    check_eq("ar_haz", bus.hazard_o, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    bus.adv_i = 0;
    settle(); check_eq("ar_byp_rf", bus.src_byp_o[DW-1:0], rfd); advance();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      bus.adv_i = ($urandom_range(0, 3) != 0);
      set_exe($urandom_range(0, 1), AW'($urandom_range(0, 3)),
              ($urandom_range(0, 2) == 0) ? '1 : NB'($urandom()), rand_data(),
              $urandom_range(0, 2) != 0);
      bus.late_valid_i = 0;
      bus.late_data_i = rand_data();
      if (pipe[LS-1].v && !pipe[LS-1].r) begin
        bus.late_valid_i = $urandom_range(0, 1);
        if (!bus.late_valid_i && $urandom_range(0, 19) != 0) bus.adv_i = 0;
      end else if ($urandom_range(0, 99) == 0) begin
        bus.late_valid_i = 1;
      end
      for (int s = 0; s < NS; s++)
        set_src(s, $urandom_range(0, 1), AW'($urandom_range(0, 3)), rand_data());
      settle();
      if ($urandom_range(0, 79) == 0) do_reset();
      else advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_v_bypass_pipe.md
Name: riscv_v_bypass_pipe

Overview:
Parametrised vector writeback pipeline with an integrated per-byte forwarding network. It replaces combinational MEM/WB-only bypassing with NUM_STAGES in-flight write records captured from EXE. It forwards to NUM_SRCS read operands using youngest-first byte priority. It raises a hazard when the youngest matching producer's data is not yet available (late/load data), and retires the oldest record into the vector register file write port.

Parameters:
DATA_WIDTH, 128, vector register width in bits (multiple of 8)
NUM_SRCS, 3, number of forwarded read operands
NUM_STAGES, 3, in-flight record stages after EXE (>=2)
LATE_STAGE, 2, stage (1..NUM_STAGES-1) at which late data must arrive
ADDR_WIDTH, 5, register address width
NB = DATA_WIDTH/8 (derived, not overridable)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
adv_i  in  1  pipeline advance; 0 holds all stages
wr_valid_exe_i  in  1  EXE instruction writes a vector register
wr_addr_exe_i  in  ADDR_WIDTH  destination register
wr_be_exe_i  in  NB  byte write enables (mask/osize already applied)
wr_data_exe_i  in  DATA_WIDTH  result data (ignored if not ready)
wr_rdy_exe_i  in  1  1 = data valid at EXE; 0 = arrives at LATE_STAGE
late_valid_i  in  1  late data present for record in LATE_STAGE
late_data_i  in  DATA_WIDTH  late data
src_valid_i  in  NUM_SRCS  operand is read this cycle
src_addr_i  in  NUM_SRCS*ADDR_WIDTH  operand register addresses, flattened
src_rf_data_i  in  NUM_SRCS*DATA_WIDTH  register file read data
src_byp_o  out  NUM_SRCS*DATA_WIDTH  forwarded operands
hazard_o  out  1  an operand byte depends on unready data; upstream must stall
rf_wr_en_o  out  NB  register file byte write enables
rf_wr_addr_o  out  ADDR_WIDTH  register file write address
rf_wr_data_o  out  DATA_WIDTH  register file write data
err_o  out  1  sticky protocol error

Behaviour:
- Each stage k (1..NUM_STAGES) holds the record {valid, addr, be, data, rdy}. On reset all fields are 0 and err_o is 0.
- When adv_i=1, stage1 captures the EXE inputs (valid = wr_valid_exe_i) and stage k+1 captures stage k. When adv_i=0, all stages hold. Latency from EXE to RF write is NUM_STAGES advancing cycles.
- Late fill: if stage LATE_STAGE is valid, has rdy=0, and late_valid_i=1, its effective data is late_data_i and its effective rdy is 1, combinationally.
  - The effective values are used for forwarding in the same cycle.
  - With adv_i=1 they are captured into stage LATE_STAGE+1.
  - With adv_i=0 they are written back in place into stage LATE_STAGE.
- Forwarding, per operand s and byte b:
  - Select the youngest stage k with valid, addr==src_addr[s], and be[b]=1. Use that stage's effective data byte.
  - With no match, use the src_rf_data byte.
  - Stages are compared as they stand this cycle; there is no EXE self-forwarding.
- hazard_o = OR over s with src_valid[s]=1 and over bytes b of (the selected record's effective rdy==0). An older ready record never masks a younger unready one.
- Retire: rf_wr_en_o = stage NUM_STAGES be replicated-AND (valid & adv_i). rf_wr_addr_o and rf_wr_data_o come directly from stage NUM_STAGES, so each retired record is written exactly once.
- err_o is set (and held until reset) when either event occurs:
  - adv_i=1 while stage LATE_STAGE is valid with effective rdy=0.
  - late_valid_i=1 while stage LATE_STAGE is not valid or is already rdy.
- Reset asserted mid-operation: all records are discarded immediately and outputs drop to 0 asynchronously.
- Same address in several stages: partial byte enables merge per byte, with the youngest stage winning.

Optional Feature:
Macro RISCV_V_BYPASS_PERF_EN.
- With the macro: adds outputs perf_fwd_cnt_o[31:0] and perf_haz_cnt_o[31:0].
  - perf_fwd_cnt_o increments by 1 in each cycle where any valid operand takes at least one byte from a stage.
  - perf_haz_cnt_o increments by 1 in each cycle where hazard_o=1.
  - Both counters reset to 0, saturate at 0xFFFF_FFFF, and count regardless of adv_i.
- Without the macro: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Back-to-back forwarding: EXE writes v3=0x11..11 (be all 1, rdy=1) with adv_i held at 1. The next cycle reads v3 with rf data 0 -> src_byp=0x11..11, hazard_o=0. After 3 advances -> rf_wr_en_o=all 1 with addr 3 for exactly one cycle.
- Partial merge: stage2 holds v5 be=0x00FF data=0xAA.., stage1 holds v5 be=0x0F0F data=0xBB.., rf data=0xCC.. -> bytes 0-3 and 8-11 are 0xBB, bytes 4-7 are 0xAA, bytes 12-15 are 0xCC.
- Load-use: EXE load to v7 with rdy=0, then read v7 -> hazard_o=1. Drive adv_i=0 until late_valid_i with data 0x55.. arrives at LATE_STAGE -> same cycle hazard_o=0 and src_byp=0x55.., err_o stays 0.
- Protocol error: advance the unready v7 record past LATE_STAGE without late_valid_i -> err_o=1, and it stays 1 until rst_n is pulsed low.
- Reset mid-flight: 3 valid records, assert rst_n=0 asynchronously between edges -> rf_wr_en_o=0 and hazard_o=0 immediately; reads after release return the rf data.
- PERF_EN: 4 forwarding cycles and 2 hazard cycles -> perf_fwd_cnt_o=4, perf_haz_cnt_o=2. With the counters preloaded near max, they hold at 0xFFFF_FFFF.
